// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction memory, redirect and decode handshake signals of the fetch stage.
// master is the fetch stage itself; slave is the surrounding memory/decode/resolve side.
interface ifetch_queue_if;
   localparam int WORD      = 64;
   localparam int INSTR_LEN = 32;
   logic                 imem_req;
   logic [WORD-1:0]      imem_addr;
   logic [INSTR_LEN-1:0] imem_rdata;
   logic                 redirect;
   logic [WORD-1:0]      redirect_pc;
   logic                 instr_valid;
   logic [INSTR_LEN-1:0] instr;
   logic [WORD-1:0]      instr_pc;
   logic                 instr_ready;
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_rdata, redirect, redirect_pc, instr_ready
   );
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with a small {instr, pc} FIFO toward decode.
// Redirects flush queued and in-flight fetches and restart fetch at the target.
module ifetch_queue #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input logic            clk,
   input logic            rst_n,
   ifetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   fetch_pc;
   logic [63:0]   inflight_pc;
   logic          inflight;
   logic          discard;
   logic [31:0]   q_instr [DEPTH];
   logic [63:0]   q_pc [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   last_instr;
   logic [63:0]   last_pc;
   logic [CW:0]   occ;
   logic          pop;
   logic          push;
   logic          credit;
   logic          issue;
   logic          valid;

   always_comb begin
      valid  = (count != '0) && !bus.redirect;
      pop    = valid && bus.instr_ready;
      push   = inflight && !discard && !bus.redirect;
      // occupancy counts the outstanding fetch so a returning word always has a slot
      occ    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
      credit = occ < (CW+1)'(DEPTH);
      issue  = rst_n && !bus.redirect && credit;
   end

   assign bus.imem_req    = issue;
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = valid;
   assign bus.instr       = (count != '0) ? q_instr[head] : last_instr;
   assign bus.instr_pc    = (count != '0) ? q_pc[head] : last_pc;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         discard     <= 1'b0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         last_instr  <= '0;
         last_pc     <= '0;
      end else begin
         fetch_pc    <= bus.redirect ? (bus.redirect_pc & ~64'h3) : issue ? fetch_pc + 64'd4 : fetch_pc;
         inflight    <= issue;
         inflight_pc <= issue ? fetch_pc : inflight_pc;
         discard     <= bus.redirect ? issue : discard && !inflight;
         head        <= bus.redirect ? '0 : head + AW'(pop);
         tail        <= bus.redirect ? '0 : tail + AW'(push);
         count       <= bus.redirect ? '0 : count + CW'(push) - CW'(pop);
         // keep the last head visible once the queue drains
         last_instr  <= (count != '0) ? q_instr[head] : last_instr;
         last_pc     <= (count != '0) ? q_pc[head] : last_pc;
      end

   always_ff @(posedge clk)
      if (push) begin
         q_instr[tail] <= bus.imem_rdata;
         q_pc[tail]    <= inflight_pc;
      end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized fetch/redirect/backpressure stimulus against an architectural
// instruction-stream scoreboard, plus directed latency, wrap and async-reset checks.
module tb_ifetch_queue;
   localparam logic [63:0] RPC   = 64'h100;
   localparam int          DEPTH = 2;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   int          compared = 0;
   int          mismatched = 0;
   int          handshakes = 0;
   item_t       exp_q[$];
   item_t       mon_e;
   logic [63:0] gen_pc;

   ifetch_queue_if bus();

   ifetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'hA5A5_0000;
   endfunction

   // synchronous memory: word for last cycle's request, junk otherwise
   always @(posedge clk) bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : $urandom;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 8) begin
         exp_q.push_back('{gen_pc, mem_word(gen_pc)});
         gen_pc += 64'd4;
      end
   endtask

   task automatic restart(input logic [63:0] target);
      exp_q.delete();
      gen_pc = target & ~64'h3;
      top_up();
   endtask

   task automatic step(input logic r, input logic rd, input logic [63:0] rpc);
      @(negedge clk);
      bus.redirect    = r;
      bus.instr_ready = rd;
      bus.redirect_pc = rpc;
      if (r) restart(rpc);
      top_up();
      #2;
   endtask

   task automatic chk_reset_vals();
      chk("rst_instr_valid", bus.instr_valid, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_instr_pc", bus.instr_pc, 0);
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_imem_addr", bus.imem_addr, RPC);
   endtask

   task automatic redir_check(input logic [63:0] target);
      logic [63:0] t;
      t = target & ~64'h3;
      step(1'b1, 1'b1, target);
      chk("redir_t_valid", bus.instr_valid, 0);
      chk("redir_t_req", bus.imem_req, 0);
      step(1'b0, 1'b1, 64'h0);
      chk("redir_t1_req", bus.imem_req, 1);
      chk("redir_t1_addr", bus.imem_addr, t);
      chk("redir_t1_valid", bus.instr_valid, 0);
      step(1'b0, 1'b1, 64'h0);
      chk("redir_t2_valid", bus.instr_valid, 0);
      step(1'b0, 1'b1, 64'h0);
      chk("redir_t3_valid", bus.instr_valid, 1);
      chk("redir_t3_pc", bus.instr_pc, t);
   endtask

   // monitor: every completed handshake must match the next architectural instruction
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         compared++;
         assert (dut.count <= DEPTH && dut.discard == 1'b0)
         else begin
            mismatched++;
            $display("FAIL occupancy: count %0d discard %0b, required count<=%0d discard 0",
                     dut.count, dut.discard, DEPTH);
         end
         if (bus.redirect) chk("valid_in_redirect", bus.instr_valid, 0);
         else if (bus.instr_valid && bus.instr_ready) begin
            handshakes++;
            mon_e = exp_q.pop_front();
            chk("stream_pc", bus.instr_pc, mon_e.pc);
            chk("stream_instr", bus.instr, mon_e.ins);
         end
      end
   end

   initial begin
      logic        r;
      logic        rd;
      logic [63:0] tg;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.instr_ready = 1'b0;
      gen_pc          = RPC;
      #1 rst_n = 1'b0;
      #2 chk_reset_vals();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.instr_ready = 1'b1;
      restart(RPC);
      #2;
      chk("c0_req", bus.imem_req, 1);
      chk("c0_addr", bus.imem_addr, RPC);
      step(1'b0, 1'b1, 64'h0);
      chk("c1_valid", bus.instr_valid, 0);
      step(1'b0, 1'b1, 64'h0);
      chk("c2_valid", bus.instr_valid, 1);
      chk("c2_pc", bus.instr_pc, RPC);
      repeat (6) begin
         step(1'b0, 1'b1, 64'h0);
         chk("stream_rate", bus.instr_valid, 1);
      end
      repeat (5) step(1'b0, 1'b0, 64'h0);
      chk("bp_req", bus.imem_req, 0);
      chk("bp_valid", bus.instr_valid, 1);
      chk("bp_count", dut.count, DEPTH);
      step(1'b0, 1'b1, 64'h0);
      chk("bp_release_req", bus.imem_req, 1);
      repeat (4) step(1'b0, 1'b1, 64'h0);
      repeat (3) step(1'b0, 1'b0, 64'h0);
      redir_check(64'h2003);
      repeat (4) step(1'b0, 1'b1, 64'h0);
      chk("collide_pre_valid", bus.instr_valid, 1);
      redir_check(64'h3000);
      repeat (3) step(1'b0, 1'b1, 64'h0);
      step(1'b1, 1'b1, 64'h400);
      chk("b2b_first_req", bus.imem_req, 0);
      redir_check(64'h800);
      repeat (3) step(1'b0, 1'b1, 64'h0);
      redir_check(64'hFFFF_FFFF_FFFF_FFFC);
      step(1'b0, 1'b1, 64'h0);
      chk("wrap_valid", bus.instr_valid, 1);
      chk("wrap_pc", bus.instr_pc, 64'h0);
      repeat (3000) begin
         r  = ($urandom_range(0, 15) == 0);
         rd = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0:       tg = {$urandom, $urandom};
            1:       tg = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default: tg = 64'($urandom_range(0, 255));
         endcase
         step(r, rd, tg);
      end
      repeat (4) step(1'b0, 1'b1, 64'h0);
      chk("throughput", handshakes > 500, 1);
      chk("async_pre_valid", bus.instr_valid, 1);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      restart(RPC);
      #2;
      chk("rerst_c0_req", bus.imem_req, 1);
      chk("rerst_c0_addr", bus.imem_addr, RPC);
      repeat (2) step(1'b0, 1'b1, 64'h0);
      chk("rerst_c2_pc", bus.instr_pc, RPC);
      repeat (4) step(1'b0, 1'b1, 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
